// File: rtl/local_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// local_cmd_arbiter
//   Shares the single 65-bit local-bus command port between NUM_REQ
//   requesters. Grants are round-robin, only one command is outstanding at a
//   time, and the granted requester receives either the read data or a
//   timeout status once the local-bus master finishes (or fails to finish).
//
//   Command format (per requester slot and on command_o):
//     [64]    1 = read, 0 = write
//     [63:32] address
//     [31:0]  write data
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-low reset
//   req_valid_i     per-requester command pending (level, held until ready)
//   req_cmd_i       requester i command at [65*i+64 : 65*i]
//   req_ready_o     one-cycle pulse: command of requester i accepted
//   resp_valid_o    one-cycle pulse: transaction of requester i finished
//   resp_data_o     read data with resp_valid_o (0 for writes / timeout)
//   resp_timeout_o  qualifies resp_valid_o: 1 = aborted on timeout
//   command_o       command to the local-bus master (held until next issue)
//   command_wr_o    one-cycle write strobe for command_o
//   cmd_done_i      one-cycle pulse from the local-bus master: complete
//   cmd_rdata_i     read data, valid with cmd_done_i
// ----------------------------------------------------------------------------
module local_cmd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*65-1:0]    req_cmd_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [NUM_REQ-1:0]       resp_valid_o,
    output logic [31:0]              resp_data_o,
    output logic                     resp_timeout_o,
    output logic [64:0]              command_o,
    output logic                     command_wr_o,
    input  logic                     cmd_done_i,
    input  logic [31:0]              cmd_rdata_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam int CMD_W = 65;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e               state_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     grant_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic [NUM_REQ-1:0]   resp_valid_q;
    logic [31:0]          resp_data_q;
    logic                 resp_timeout_q;
    logic [CMD_W-1:0]     command_q;
    logic                 command_wr_q;

    logic [IDX_W-1:0]     grant_s;
    logic [CMD_W-1:0]     grant_cmd_s;
    logic [IDX_W-1:0]     rr_next_s;
    logic                 timeout_hit_s;

    // First set bit of valid, searching upward from ptr and wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        logic [IDX_W:0]   cand;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end else begin
                cand = cand;
            end
            if (!found && valid[cand[IDX_W-1:0]]) begin
                pick  = cand[IDX_W-1:0];
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Grant candidate and its command, evaluated against the current rr pointer.
    always_comb begin
        grant_s     = rr_pick(req_valid_i, rr_ptr_q);
        grant_cmd_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s == IDX_W'(i)) begin
                grant_cmd_s = req_cmd_i[CMD_W*i +: CMD_W];
            end else begin
                grant_cmd_s = grant_cmd_s;
            end
        end
    end

    // Pointer following the active grant, and the timeout-limit detect.
    always_comb begin
        if (grant_q == IDX_W'(NUM_REQ-1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_q + IDX_W'(1);
        end
        timeout_hit_s = (cnt_q == CNT_W'(TIMEOUT-1));
    end

    // Arbiter FSM with all outputs registered. Outputs that must be visible
    // during ISSUE/RESP are loaded on the edge that enters those states.
    // The counter is 0 during ISSUE, so it equals cycles-since-issue in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            cnt_q          <= '0;
            req_ready_q    <= '0;
            resp_valid_q   <= '0;
            resp_data_q    <= 32'd0;
            resp_timeout_q <= 1'b0;
            command_q      <= '0;
            command_wr_q   <= 1'b0;
        end else begin
            req_ready_q  <= '0;
            command_wr_q <= 1'b0;
            resp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        grant_q      <= grant_s;
                        command_q    <= grant_cmd_s;
                        command_wr_q <= 1'b1;
                        req_ready_q  <= to_onehot(grant_s);
                        cnt_q        <= '0;
                        state_q      <= ST_ISSUE;
                    end else begin
                        state_q      <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= cnt_q + CNT_W'(1);
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion takes priority over the timeout limit.
                    if (cmd_done_i) begin
                        resp_valid_q   <= to_onehot(grant_q);
                        resp_timeout_q <= 1'b0;
                        resp_data_q    <= command_q[64] ? cmd_rdata_i : 32'd0;
                        state_q        <= ST_RESP;
                    end else if (timeout_hit_s) begin
                        resp_valid_q   <= to_onehot(grant_q);
                        resp_timeout_q <= 1'b1;
                        resp_data_q    <= 32'd0;
                        state_q        <= ST_RESP;
                    end else begin
                        cnt_q          <= cnt_q + CNT_W'(1);
                        state_q        <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    resp_timeout_q <= 1'b0;
                    resp_data_q    <= 32'd0;
                    rr_ptr_q       <= rr_next_s;
                    state_q        <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o    = req_ready_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_data_o    = resp_data_q;
    assign resp_timeout_o = resp_timeout_q;
    assign command_o      = command_q;
    assign command_wr_o   = command_wr_q;

endmodule

// File: tb/tb_local_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_local_cmd_arbiter
//   Directed bench for local_cmd_arbiter. Stimulus pushes the expected issue
//   and response events (with their absolute cycle) into queues; a monitor
//   pops and compares whenever the DUT pulses req_ready/command_wr or
//   resp_valid. A small local-bus model answers each issued command after a
//   per-transaction delay (0 = never answers).
// ----------------------------------------------------------------------------
module tb_local_cmd_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*65-1:0] req_cmd;
    logic [NREQ-1:0]   req_ready_o;
    logic [NREQ-1:0]   resp_valid_o;
    logic [31:0]       resp_data_o;
    logic              resp_timeout_o;
    logic [64:0]       command_o;
    logic              command_wr_o;
    logic              cmd_done  = 1'b0;
    logic [31:0]       cmd_rdata = 32'd0;

    local_cmd_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid),
        .req_cmd_i      (req_cmd),
        .req_ready_o    (req_ready_o),
        .resp_valid_o   (resp_valid_o),
        .resp_data_o    (resp_data_o),
        .resp_timeout_o (resp_timeout_o),
        .command_o      (command_o),
        .command_wr_o   (command_wr_o),
        .cmd_done_i     (cmd_done),
        .cmd_rdata_i    (cmd_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int idx; logic [64:0] cmd; int cyc; } iss_t;
    typedef struct { int idx; logic [31:0] data; logic to; int cyc; } rsp_t;

    iss_t        exp_iss[$];
    rsp_t        exp_rsp[$];
    int          dly_q[$];
    logic [31:0] rd_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int stray_at = -1;

    function automatic logic [3:0] oh4(input int idx);
        logic [3:0] v;
        v = 4'b0001;
        return v << idx;
    endfunction

    function automatic logic [64:0] mk_cmd(input logic rd, input logic [31:0] a, input logic [31:0] d);
        return {rd, a, d};
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Expect an issue only (bus never answers): used where reset cuts it short.
    task automatic expect_issue(input int idx, input logic [64:0] c, input int icyc,
                                input int dly, input logic [31:0] rd);
        iss_t e;
        e.idx = idx; e.cmd = c; e.cyc = icyc;
        exp_iss.push_back(e);
        dly_q.push_back(dly);
        rd_q.push_back(rd);
    endtask

    // Expect issue at icyc and the response that follows. dly=0: no cmd_done,
    // so a timeout response TMO cycles after issue; otherwise cmd_done arrives
    // dly cycles after issue and the response one cycle later.
    task automatic expect_txn(input int idx, input logic [64:0] c, input int icyc,
                              input int dly, input logic [31:0] rd);
        rsp_t r;
        expect_issue(idx, c, icyc, dly, rd);
        r.idx = idx;
        if (dly == 0) begin
            r.data = 32'd0; r.to = 1'b1; r.cyc = icyc + TMO;
        end else begin
            r.data = c[64] ? rd : 32'd0; r.to = 1'b0; r.cyc = icyc + dly + 1;
        end
        exp_rsp.push_back(r);
    endtask

    // Local-bus model: schedules cmd_done after each issued command.
    int          bus_pend = 0;
    int          bus_done_at = 0;
    logic [31:0] bus_rd = 32'd0;
    int          bus_d;
    logic [31:0] bus_r;
    always @(negedge clk) begin
        cmd_done  = 1'b0;
        cmd_rdata = 32'd0;
        if (bus_pend != 0 && cyc == bus_done_at) begin
            cmd_done  = 1'b1;
            cmd_rdata = bus_rd;
            bus_pend  = 0;
        end
        if (cyc == stray_at) begin
            cmd_done  = 1'b1;
            cmd_rdata = 32'hBAD0_BAD0;
        end
        if (reset && command_wr_o) begin
            bus_d = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
            bus_r = (rd_q.size() > 0) ? rd_q.pop_front() : 32'd0;
            if (bus_d > 0) begin
                bus_pend    = 1;
                bus_done_at = cyc + bus_d;
                bus_rd      = bus_r;
            end
        end
        if (!reset) bus_pend = 0;
    end

    // Monitor / scoreboard.
    int   outstanding = 0;
    iss_t ei;
    rsp_t er;
    always @(negedge clk) begin
        if (!reset) begin
            outstanding = 0;
        end else begin
            if (command_wr_o || (req_ready_o != 4'b0000)) begin
                n_checks++;
                if (exp_iss.size() == 0) begin
                    n_errors++;
                    $display("FAIL issue: unexpected req_ready=%b command_wr=%b cmd=%h at cycle %0d, required none",
                             req_ready_o, command_wr_o, command_o, cyc);
                end else begin
                    ei = exp_iss.pop_front();
                    if (command_wr_o !== 1'b1 || req_ready_o !== oh4(ei.idx) ||
                        command_o !== ei.cmd || cyc != ei.cyc) begin
                        n_errors++;
                        $display("FAIL issue: got ready=%b wr=%b cmd=%h cycle=%0d, required ready=%b wr=1 cmd=%h cycle=%0d",
                                 req_ready_o, command_wr_o, command_o, cyc, oh4(ei.idx), ei.cmd, ei.cyc);
                    end
                end
                n_checks++;
                if (outstanding != 0) begin
                    n_errors++;
                    $display("FAIL single_outstanding: got %0d outstanding at issue cycle %0d, required 0",
                             outstanding, cyc);
                end
                outstanding = 1;
            end
            if (resp_valid_o != 4'b0000) begin
                n_checks++;
                if (exp_rsp.size() == 0) begin
                    n_errors++;
                    $display("FAIL resp: unexpected resp_valid=%b data=%h to=%b at cycle %0d, required none",
                             resp_valid_o, resp_data_o, resp_timeout_o, cyc);
                end else begin
                    er = exp_rsp.pop_front();
                    if (resp_valid_o !== oh4(er.idx) || resp_data_o !== er.data ||
                        resp_timeout_o !== er.to || cyc != er.cyc) begin
                        n_errors++;
                        $display("FAIL resp: got valid=%b data=%h to=%b cycle=%0d, required valid=%b data=%h to=%b cycle=%0d",
                                 resp_valid_o, resp_data_o, resp_timeout_o, cyc,
                                 oh4(er.idx), er.data, er.to, er.cyc);
                    end
                end
                outstanding = 0;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"},    65'(req_ready_o),    65'd0);
        chk({tag, "_resp_valid"},   65'(resp_valid_o),   65'd0);
        chk({tag, "_resp_data"},    65'(resp_data_o),    65'd0);
        chk({tag, "_resp_timeout"}, 65'(resp_timeout_o), 65'd0);
        chk({tag, "_command"},      command_o,           65'd0);
        chk({tag, "_command_wr"},   65'(command_wr_o),   65'd0);
    endtask

    int n;
    int m;
    logic [64:0] c0, c1, c2, c3;

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // Round robin with all requesters pending: 0,1,2,3,0,1,2,3.
        n = cyc;
        for (int k = 0; k < NREQ; k++) begin
            req_cmd[65*k +: 65] = mk_cmd(((k % 2) == 0) ? 1'b1 : 1'b0,
                                         32'h0000_0100 + 32'(k), 32'h1111_0000 + 32'(k));
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            expect_txn(k % 4, req_cmd[65*(k%4) +: 65], n + 1 + 4*k, 1, 32'hD000_0000 + 32'(k));
        end
        wait_cyc(n + 30);
        req_valid = '0;
        wait_cyc(n + 36);

        // Single read from requester 2, cmd_done 3 cycles after issue.
        n  = cyc;
        c2 = mk_cmd(1'b1, 32'h0000_0010, 32'h0);
        req_cmd[65*2 +: 65] = c2;
        req_valid = 4'b0100;
        expect_txn(2, c2, n + 1, 3, 32'hCAFE_F00D);
        wait_cyc(n + 1);
        req_valid = '0;
        wait_cyc(n + 10);

        // Write times out on requester 3; requester 0 is granted next.
        n  = cyc;
        c3 = mk_cmd(1'b0, 32'h0000_0200, 32'h1234_5678);
        c0 = mk_cmd(1'b1, 32'h0000_0300, 32'h0);
        req_cmd[65*3 +: 65] = c3;
        req_cmd[65*0 +: 65] = c0;
        req_valid = 4'b1001;
        expect_txn(3, c3, n + 1, 0, 32'h0);
        expect_txn(0, c0, n + TMO + 3, 2, 32'hBEEF_0001);
        wait_cyc(n + 1);
        req_valid = 4'b0001;
        wait_cyc(n + TMO + 3);
        req_valid = '0;
        wait_cyc(n + TMO + 10);

        // cmd_done on the timeout-limit cycle: normal completion wins.
        n  = cyc;
        c1 = mk_cmd(1'b1, 32'h0000_0400, 32'h0);
        req_cmd[65*1 +: 65] = c1;
        req_valid = 4'b0010;
        expect_txn(1, c1, n + 1, TMO - 1, 32'h4444_5555);
        wait_cyc(n + 1);
        req_valid = '0;
        wait_cyc(n + TMO + 6);

        // Withdrawn request while busy, then a stray cmd_done in IDLE.
        n  = cyc;
        c2 = mk_cmd(1'b0, 32'h0000_0500, 32'hAAAA_5555);
        req_cmd[65*2 +: 65] = c2;
        req_valid = 4'b0100;
        expect_txn(2, c2, n + 1, 4, 32'h5555_AAAA);
        stray_at = n + 9;
        wait_cyc(n + 1);
        req_valid = '0;
        wait_cyc(n + 2);
        req_cmd[65*3 +: 65] = mk_cmd(1'b1, 32'h0000_0BAD, 32'h0);
        req_valid = 4'b1000;
        wait_cyc(n + 4);
        req_valid = '0;
        wait_cyc(n + 20);
        chk("command_held", command_o, c2);

        // Reset during WAIT, then pending requests reissued from pointer 0.
        n  = cyc;
        c1 = mk_cmd(1'b1, 32'h0000_0600, 32'h0);
        c3 = mk_cmd(1'b0, 32'h0000_0700, 32'h0000_0077);
        req_cmd[65*1 +: 65] = c1;
        req_valid = 4'b0010;
        expect_issue(1, c1, n + 1, 0, 32'h0);
        wait_cyc(n + 3);
        req_cmd[65*3 +: 65] = c3;
        req_valid = 4'b1010;
        wait_cyc(n + 5);
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m = cyc;
        expect_txn(1, c1, m + 1, 2, 32'h6666_0001);
        expect_txn(3, c3, m + 6, 2, 32'h7777_0000);
        wait_cyc(m + 1);
        req_valid = 4'b1000;
        wait_cyc(m + 6);
        req_valid = '0;
        wait_cyc(m + 14);

        chk("pending_issues", 65'(exp_iss.size()), 65'd0);
        chk("pending_resps",  65'(exp_rsp.size()), 65'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
